xbar_out_mux: RTL and testbench

Per-master-port output stage of the StreamXBar crossbar, directly downstream of `round_robin`. Consumes the arbiter's one-hot `grant` vector and locks onto the granted slave input for one whole AXI-Stream packet. Forwards that packet's beats to the master port and returns a one-cycle per-input packet-done pulse that drives the arbiter's `s_last_i`.

---
 rtl/xbar_pkg.sv | 22 ++
 rtl/axis_skid_buffer.sv | 58 +++++
 rtl/xbar_out_mux.sv | 129 ++++++++++++
 tb/tb_xbar_out_mux.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// xbar_pkg
// Shared definitions for the StreamXBar crossbar (output mux and round_robin).
//   XBAR_NUM_REQUEST / XBAR_DATA_WIDTH : default port count and tdata width
//   mux_state_e                        : output-mux FSM states
//   is_onehot()                        : exactly-one-bit-set test (vectors up to 32 bits)
package xbar_pkg;

    localparam int XBAR_NUM_REQUEST = 4;
    localparam int XBAR_DATA_WIDTH  = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PASS    = 2'd1,
        RELEASE = 2'd2
    } mux_state_e;

    // Callers zero-extend narrower vectors; v & (v-1) clears the lowest set bit.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer
// Two-entry AXI-Stream register slice. Ready toward the source depends only on
// the occupancy register, so there is no combinational path from m_ready_i to
// s_ready_o, while a push and a pop in the same cycle still give 1 beat/cycle.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   s_data_i/s_valid_i  : upstream beat,  s_ready_o : room available
//   m_data_o/m_valid_o  : head of queue,  m_ready_i : downstream accepts
module axis_skid_buffer #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_data_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_cnt;
    logic             w_push;
    logic             w_pop;

    assign s_ready_o = (r_cnt != 2'd2);
    assign m_valid_o = (r_cnt != 2'd0);
    assign m_data_o  = r_mem[r_rptr];
    assign w_push    = s_valid_i & s_ready_o;
    assign w_pop     = m_valid_o & m_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= s_data_i;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/xbar_out_mux.sv
// xbar_out_mux
// Per-master-port output stage of StreamXBar. Locks onto the one-hot grant from
// round_robin for a whole packet, forwards its beats, then pulses s_last_o for
// the finished input so the arbiter can rotate.
// Ports:
//   clk, rst_n                        : clock, asynchronous active-low reset
//   grant_i                           : one-hot grant from the arbiter
//   s_tdata_i/s_tvalid_i/s_tlast_i    : packed slave inputs, s_tready_o per input
//   m_tdata_o/m_tvalid_o/m_tlast_o    : master output, m_tready_i from downstream
//   s_last_o                          : one-cycle packet-done pulse per input
//   busy_o                            : FSM not in IDLE
// Build option: define XBAR_OUT_MUX_SKID_EN to register the master path through
// a 2-entry skid buffer; otherwise the master port is combinational.
module xbar_out_mux
    import xbar_pkg::*;
#(
    parameter int NUM_REQUEST = XBAR_NUM_REQUEST,
    parameter int DATA_WIDTH  = XBAR_DATA_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQUEST-1:0]            grant_i,
    input  logic [NUM_REQUEST*DATA_WIDTH-1:0] s_tdata_i,
    input  logic [NUM_REQUEST-1:0]            s_tvalid_i,
    input  logic [NUM_REQUEST-1:0]            s_tlast_i,
    output logic [NUM_REQUEST-1:0]            s_tready_o,
    output logic [DATA_WIDTH-1:0]             m_tdata_o,
    output logic                              m_tvalid_o,
    output logic                              m_tlast_o,
    input  logic                              m_tready_i,
    output logic [NUM_REQUEST-1:0]            s_last_o,
    output logic                              busy_o
);

    mux_state_e             r_state;
    logic [NUM_REQUEST-1:0] r_sel;
    logic [NUM_REQUEST-1:0] r_s_last;
    logic                   r_busy;

    logic [DATA_WIDTH-1:0]  w_data;
    logic                   w_valid;
    logic                   w_last;
    logic                   w_pass;
    logic                   w_rdy;
    logic                   w_fire;

    // AND-OR mux: r_sel is one-hot, so at most one slice survives.
    always_comb begin
        w_data = '0;
        for (int k = 0; k < NUM_REQUEST; k++) begin
            w_data = w_data | ({DATA_WIDTH{r_sel[k]}} & s_tdata_i[k*DATA_WIDTH +: DATA_WIDTH]);
        end
    end
    assign w_valid = |(r_sel & s_tvalid_i);
    assign w_last  = |(r_sel & s_tlast_i);
    assign w_pass  = (r_state == PASS);

`ifdef XBAR_OUT_MUX_SKID_EN
    logic                w_skid_ready;
    logic [DATA_WIDTH:0] w_skid_data;

    // Ready comes from state and buffer occupancy registers only.
    assign w_rdy = w_pass & w_skid_ready;

    axis_skid_buffer #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data_i  ({w_last, w_data}),
        .s_valid_i (w_pass & w_valid),
        .s_ready_o (w_skid_ready),
        .m_data_o  (w_skid_data),
        .m_valid_o (m_tvalid_o),
        .m_ready_i (m_tready_i)
    );

    assign m_tdata_o = w_skid_data[DATA_WIDTH-1:0];
    assign m_tlast_o = w_skid_data[DATA_WIDTH];
`else
    assign w_rdy      = w_pass & m_tready_i;
    assign m_tvalid_o = w_pass & w_valid;
    assign m_tdata_o  = w_pass ? w_data : '0;
    assign m_tlast_o  = w_pass & w_last;
`endif

    assign s_tready_o = w_rdy ? r_sel : '0;
    assign w_fire     = w_rdy & w_valid;

    // RELEASE exists so the arbiter sees s_last_o for one edge before IDLE
    // samples grant_i again; otherwise IDLE would re-lock on a stale grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_sel    <= '0;
            r_s_last <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_s_last <= '0;
            case (r_state)
                IDLE: begin
                    if (is_onehot(32'(grant_i))) begin
                        r_sel   <= grant_i;
                        r_state <= PASS;
                        r_busy  <= 1'b1;
                    end
                end
                PASS: begin
                    if (w_fire & w_last) begin
                        r_state  <= RELEASE;
                        r_s_last <= r_sel;
                    end
                end
                RELEASE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign s_last_o = r_s_last;
    assign busy_o   = r_busy;

endmodule

// File: tb/tb_xbar_out_mux.sv
// tb_xbar_out_mux
// Directed bench for xbar_out_mux (NUM_REQUEST=4, DATA_WIDTH=32). A negedge
// monitor records every master handshake and every s_last_o pulse; each test
// task drives its scenario and compares against hand-computed values.
module tb_xbar_out_mux;

    localparam int NR = 4;
    localparam int DW = 32;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     grant_i;
    logic [NR*DW-1:0]  s_tdata_i;
    logic [NR-1:0]     s_tvalid_i;
    logic [NR-1:0]     s_tlast_i;
    logic [NR-1:0]     s_tready_o;
    logic [DW-1:0]     m_tdata_o;
    logic              m_tvalid_o;
    logic              m_tlast_o;
    logic              m_tready_i;
    logic [NR-1:0]     s_last_o;
    logic              busy_o;

    int passed = 0;
    int total  = 0;

    logic [DW:0]   q[$];
    int            sl_cnt  = 0;
    logic [NR-1:0] sl_val  = '0;
    logic [NR-1:0] sl_prev = '0;
    bit            sl_bad  = 0;

    xbar_out_mux #(.NUM_REQUEST(NR), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .grant_i    (grant_i),
        .s_tdata_i  (s_tdata_i),
        .s_tvalid_i (s_tvalid_i),
        .s_tlast_i  (s_tlast_i),
        .s_tready_o (s_tready_o),
        .m_tdata_o  (m_tdata_o),
        .m_tvalid_o (m_tvalid_o),
        .m_tlast_o  (m_tlast_o),
        .m_tready_i (m_tready_i),
        .s_last_o   (s_last_o),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs only change #1 after posedge, so a negedge sample predicts the next edge.
    always @(negedge clk) begin
        if (rst_n && m_tvalid_o && m_tready_i) q.push_back({m_tlast_o, m_tdata_o});
        if (s_last_o != '0) begin
            sl_cnt++;
            sl_val = s_last_o;
            if (sl_prev != '0 || !$onehot(s_last_o)) sl_bad = 1;
        end
        sl_prev = s_last_o;
    end

    task automatic send_beat(input int k, input logic [DW-1:0] d, input logic l);
        bit done = 0;
        s_tdata_i[k*DW +: DW] = d;
        s_tvalid_i[k] = 1'b1;
        s_tlast_i[k]  = l;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (s_tready_o[k]) done = 1;
            @(posedge clk); #1;
        end
        s_tvalid_i[k] = 1'b0;
        s_tlast_i[k]  = 1'b0;
        if (!done) begin
            total++;
            $display("FAIL send_beat_timeout input=%0d data=%h: no ready within 20 cycles", k, d);
        end
    endtask

    task automatic lock(input logic [NR-1:0] g);
        @(posedge clk); #1;
        grant_i = g;
        @(posedge clk); #1;
        grant_i = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({s_tready_o, m_tvalid_o, m_tlast_o, s_last_o, busy_o} !== '0 || m_tdata_o !== '0) begin
            $display("FAIL reset_outputs: got rdy=%b v=%b l=%b d=%h sl=%b busy=%b, want all 0",
                     s_tready_o, m_tvalid_o, m_tlast_o, m_tdata_o, s_last_o, busy_o);
        end else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy_o !== 1'b0 || s_tready_o !== '0) begin
            $display("FAIL reset_idle: got busy=%b rdy=%b, want 0/0000", busy_o, s_tready_o);
        end else passed++;
    endtask

    task automatic test_basic;
        logic [DW:0] exp [3];
        exp[0] = {1'b0, 32'hA0}; exp[1] = {1'b0, 32'hA1}; exp[2] = {1'b1, 32'hA2};
        q.delete(); sl_cnt = 0;
        lock(4'b0001);
        @(negedge clk);
        total++;
        if (busy_o !== 1'b1 || s_tready_o !== 4'b0001) begin
            $display("FAIL basic_lock: got busy=%b rdy=%b, want 1/0001", busy_o, s_tready_o);
        end else passed++;
        @(posedge clk); #1;   // the bench-side beat loop starts on a fresh cycle
        send_beat(0, 32'hA0, 1'b0);
        send_beat(0, 32'hA1, 1'b0);
        send_beat(0, 32'hA2, 1'b1);
        @(negedge clk);
        total++;
        if (s_last_o !== 4'b0001 || busy_o !== 1'b1) begin
            $display("FAIL basic_release: got sl=%b busy=%b, want 0001/1", s_last_o, busy_o);
        end else passed++;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (s_last_o !== 4'b0000 || busy_o !== 1'b0) begin
            $display("FAIL basic_busy_fall: got sl=%b busy=%b, want 0000/0", s_last_o, busy_o);
        end else passed++;
        idle(3);
        total++;
        if (q.size() !== 3) begin
            $display("FAIL basic_count: got %0d beats, want 3", q.size());
        end else passed++;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (((i < q.size()) ? q[i] : 'x) !== exp[i]) begin
                $display("FAIL basic_beat%0d: got %h want %h", i, (i < q.size()) ? q[i] : 'x, exp[i]);
            end else passed++;
        end
        total++;
        if (sl_cnt !== 1 || sl_val !== 4'b0001) begin
            $display("FAIL basic_slast: got %0d pulses last=%b, want 1 pulse 0001", sl_cnt, sl_val);
        end else passed++;
    endtask

    task automatic test_grant_switch;
        q.delete(); sl_cnt = 0;
        lock(4'b0100);
        send_beat(2, 32'hC0, 1'b0);
        grant_i = 4'b1000;
        s_tdata_i[3*DW +: DW] = 32'hDEAD;
        s_tvalid_i[3] = 1'b1;
        s_tlast_i[3]  = 1'b1;
        @(negedge clk);
        total++;
        if (s_tready_o !== 4'b0100) begin
            $display("FAIL switch_ready: got %b want 0100", s_tready_o);
        end else passed++;
        @(posedge clk); #1;
        send_beat(2, 32'hC1, 1'b0);
        send_beat(2, 32'hC2, 1'b1);
        grant_i = '0;
        @(negedge clk);
        total++;
        if (s_last_o !== 4'b0100) begin
            $display("FAIL switch_slast: got %b want 0100", s_last_o);
        end else passed++;
        @(posedge clk); #1;
        s_tvalid_i[3] = 1'b0;
        s_tlast_i[3]  = 1'b0;
        idle(3);
        total++;
        if (q.size() !== 3 || q[0] !== {1'b0, 32'hC0} || q[1] !== {1'b0, 32'hC1} || q[2] !== {1'b1, 32'hC2}) begin
            $display("FAIL switch_stream: got %0d beats first=%h last=%h, want C0,C1,C2(last)",
                     q.size(), (q.size() > 0) ? q[0] : 'x, (q.size() > 0) ? q[q.size()-1] : 'x);
        end else passed++;
    endtask

    task automatic test_multihot;
        grant_i = 4'b0110;
        s_tvalid_i = 4'b0110;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (busy_o !== 1'b0 || s_tready_o !== '0 || m_tvalid_o !== 1'b0) begin
                $display("FAIL multihot_cycle%0d: got busy=%b rdy=%b mv=%b, want 0/0000/0",
                         c, busy_o, s_tready_o, m_tvalid_o);
            end else passed++;
            @(posedge clk); #1;
        end
        grant_i = '0;
        s_tvalid_i = '0;
    endtask

    task automatic test_single_beat;
        q.delete(); sl_cnt = 0;
        lock(4'b0010);
        send_beat(1, 32'h55, 1'b1);
        @(negedge clk);
        total++;
        if (s_last_o !== 4'b0010) begin
            $display("FAIL single_slast: got %b want 0010", s_last_o);
        end else passed++;
        idle(4);
        total++;
        if (q.size() !== 1 || q[0] !== {1'b1, 32'h55}) begin
            $display("FAIL single_beat: got %0d beats first=%h, want 1 beat 1_00000055",
                     q.size(), (q.size() > 0) ? q[0] : 'x);
        end else passed++;
        total++;
        if (sl_cnt !== 1) begin
            $display("FAIL single_pulses: got %0d want 1", sl_cnt);
        end else passed++;
    endtask

    task automatic test_backpressure;
        logic [NR-1:0] exp_rdy1;
`ifdef XBAR_OUT_MUX_SKID_EN
        exp_rdy1 = 4'b0001;
`else
        exp_rdy1 = 4'b0000;
`endif
        q.delete();
        lock(4'b0001);
        m_tready_i = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send_beat(0, 32'hB0 + 32'(i), (i == 3));
            end
            begin
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    if (c >= 1) begin
                        total++;
                        if (m_tvalid_o !== 1'b1 || m_tdata_o !== 32'hB0 || m_tlast_o !== 1'b0) begin
                            $display("FAIL bp_hold_c%0d: got v=%b d=%h l=%b, want 1/000000b0/0",
                                     c, m_tvalid_o, m_tdata_o, m_tlast_o);
                        end else passed++;
                    end
                    if (c == 1) begin
                        total++;
                        if (s_tready_o !== exp_rdy1) begin
                            $display("FAIL bp_ready_c1: got %b want %b", s_tready_o, exp_rdy1);
                        end else passed++;
                    end
                    if (c >= 2) begin
                        total++;
                        if (s_tready_o !== 4'b0000) begin
                            $display("FAIL bp_ready_c%0d: got %b want 0000", c, s_tready_o);
                        end else passed++;
                    end
                end
                @(posedge clk); #1;
                m_tready_i = 1'b1;
            end
        join
        idle(5);
        total++;
        if (q.size() !== 4) begin
            $display("FAIL bp_count: got %0d beats want 4", q.size());
        end else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (((i < q.size()) ? q[i] : 'x) !== {(i == 3), 32'hB0 + 32'(i)}) begin
                $display("FAIL bp_beat%0d: got %h want %h", i, (i < q.size()) ? q[i] : 'x,
                         {(i == 3), 32'hB0 + 32'(i)});
            end else passed++;
        end
    endtask

    task automatic test_reset_midpacket;
        int cnt0;
        lock(4'b0001);
        send_beat(0, 32'hD0, 1'b0);
        s_tdata_i[0 +: DW] = 32'hD1;
        s_tvalid_i[0] = 1'b1;
        cnt0 = sl_cnt;
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({s_tready_o, m_tvalid_o, m_tlast_o, s_last_o, busy_o} !== '0 || m_tdata_o !== '0) begin
            $display("FAIL midrst_outputs: got rdy=%b v=%b l=%b d=%h sl=%b busy=%b, want all 0",
                     s_tready_o, m_tvalid_o, m_tlast_o, m_tdata_o, s_last_o, busy_o);
        end else passed++;
        s_tvalid_i = '0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        total++;
        if (sl_cnt !== cnt0) begin
            $display("FAIL midrst_no_slast: got %0d pulses want %0d", sl_cnt, cnt0);
        end else passed++;
        q.delete();
        lock(4'b1000);
        send_beat(3, 32'hE0, 1'b0);
        send_beat(3, 32'hE1, 1'b1);
        idle(4);
        total++;
        if (q.size() !== 2 || q[0] !== {1'b0, 32'hE0} || q[1] !== {1'b1, 32'hE1}) begin
            $display("FAIL midrst_next_pkt: got %0d beats first=%h, want E0,E1(last)",
                     q.size(), (q.size() > 0) ? q[0] : 'x);
        end else passed++;
        total++;
        if (sl_val !== 4'b1000 || sl_cnt !== cnt0 + 1) begin
            $display("FAIL midrst_next_slast: got %b cnt=%0d want 1000 cnt=%0d", sl_val, sl_cnt, cnt0 + 1);
        end else passed++;
    endtask

    initial begin
        rst_n      = 1'b0;
        grant_i    = '0;
        s_tdata_i  = '0;
        s_tvalid_i = '0;
        s_tlast_i  = '0;
        m_tready_i = 1'b1;
        test_reset;
        test_basic;
        test_grant_switch;
        test_multihot;
        test_single_beat;
        test_backpressure;
        test_reset_midpacket;
        total++;
        if (sl_bad !== 1'b0) begin
            $display("FAIL slast_shape: got a multi-bit or multi-cycle s_last_o pulse");
        end else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
